shift_sub_divider: RTL

Sequential unsigned divider, counterpart of the shift-add multiplier: divides a 2N-bit dividend by an N-bit divisor by restoring shift-and-subtract, one quotient bit per clock. Control FSM and datapath in one block, with the multiplier's St/Idle/Done handshake. Detects quotient overflow, including divide-by-zero, before iterating.

---
 rtl/shift_sub_divider.sv | 108 ++++++++++
 1 files changed

// File: rtl/shift_sub_divider.sv
// shift_sub_divider
//   Sequential unsigned restoring divider. It divides a 2N-bit dividend by an
//   N-bit divisor and produces one quotient bit per clock. It uses the
//   St/Idle/Done handshake of the shift-add multiplier.
//   Quotient overflow, including divide-by-zero, is detected in a single CHECK
//   cycle before any iteration starts.
//
// Ports
//   Clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   St         start request, sampled only while Idle
//   Dividend   2N-bit unsigned dividend, captured on an accepted St
//   Divisor    N-bit unsigned divisor, captured on an accepted St
//   Quotient   low half of the accumulator
//   Remainder  high half of the accumulator
//   V          overflow flag, held until the next accepted St
//   Idle       FSM is in IDLE
//   Done       one-cycle result-valid strobe
module shift_sub_divider #(
    parameter int N = 4
) (
    input  logic           Clk,
    input  logic           rst_n,
    input  logic           St,
    input  logic [2*N-1:0] Dividend,
    input  logic [N-1:0]   Divisor,
    output logic [N-1:0]   Quotient,
    output logic [N-1:0]   Remainder,
    output logic           V,
    output logic           Idle,
    output logic           Done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

    state_t          state, state_n;
    logic [2*N-1:0]  acc;
    logic [N-1:0]    dvs;
    logic [CW-1:0]   cnt;
    logic            v_q;

    // The trial window includes the bit about to be shifted in. The upper half
    // can be as large as DVS-1, so it needs N+1 bits.
    logic [N:0]      t;
    logic [N:0]      diff;
    logic            t_ge;
    logic            ovf;

    assign t    = {acc[2*N-1:N], acc[N-1]};
    assign t_ge = (t >= {1'b0, dvs});
    assign diff = t - {1'b0, dvs};
    // If the upper half already reaches the divisor, the quotient cannot fit
    // in N bits. A zero divisor always takes this path.
    assign ovf  = (acc[2*N-1:N] >= dvs);

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (St) state_n = S_CHECK;
            S_CHECK: state_n = ovf ? S_DONE : S_RUN;
            S_RUN:   if (cnt == LAST) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            dvs <= '0;
            cnt <= '0;
            v_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (St) begin
                    acc <= Dividend;
                    dvs <= Divisor;
                    cnt <= '0;
                    v_q <= 1'b0;
                end
                S_CHECK: if (ovf) v_q <= 1'b1;
                S_RUN: begin
                    // diff[N] is always 0 when t_ge because the upper half
                    // stays below DVS, so the difference fits in N bits.
                    if (t_ge) acc <= {diff[N-1:0], acc[N-2:0], 1'b1};
                    else      acc <= {acc[2*N-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Quotient  = acc[N-1:0];
    assign Remainder = acc[2*N-1:N];
    assign V         = v_q;
    assign Idle      = (state == S_IDLE);
    assign Done      = (state == S_DONE);

endmodule
